// File: rtl/alu.sv
// alu: registered 32-bit MIPS-style execute-stage ALU with branch-condition flag
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic [4:0]  shamt,
  input  logic [5:0]  ALU_control,
  input  logic [15:0] immediate,
  output logic [31:0] ALU_result,
  output logic        sig_branch
);
  logic [31:0] se, ze, res;
  logic [4:0]  sv;
  logic        br;
  assign se = {{16{immediate[15]}}, immediate};
  assign ze = {16'h0000, immediate};
  assign sv = rs_content[4:0];
  // decode opcode/funct into next result and branch flag
  always_comb begin
    res = '0;
    br  = 1'b0;
    case (opcode)
      6'b000000:
        case (ALU_control)
          6'b000000: res = rt_content << shamt;
          6'b000010: res = rt_content >> shamt;
          6'b000011: res = $signed(rt_content) >>> shamt;
          6'b000100: res = rt_content << sv;
          6'b000110: res = rt_content >> sv;
          6'b000111: res = $signed(rt_content) >>> sv;
          6'b100000, 6'b100001: res = rs_content + rt_content;
          6'b100010, 6'b100011: res = rs_content - rt_content;
          6'b100100: res = rs_content & rt_content;
          6'b100101: res = rs_content | rt_content;
          6'b100110: res = rs_content ^ rt_content;
          6'b100111: res = ~(rs_content | rt_content);
          6'b101010: res = {31'b0, $signed(rs_content) < $signed(rt_content)};
          6'b101011: res = {31'b0, rs_content < rt_content};
          default:   res = '0;
        endcase
      6'b001000, 6'b001001, 6'b100011, 6'b101011: res = rs_content + se;
      6'b001010: res = {31'b0, $signed(rs_content) < $signed(se)};
      6'b001011: res = {31'b0, rs_content < se};
      6'b001100: res = rs_content & ze;
      6'b001101: res = rs_content | ze;
      6'b001110: res = rs_content ^ ze;
      6'b001111: res = {immediate, 16'h0000};
      6'b000100: br = rs_content == rt_content;
      6'b000101: br = rs_content != rt_content;
      6'b000110: br = $signed(rs_content) <= 32'sd0;
      6'b000111: br = $signed(rs_content) > 32'sd0;
      default: begin
        res = '0;
        br  = 1'b0;
      end
    endcase
  end
  // output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_result <= '0;
      sig_branch <= 1'b0;
    end else begin
      ALU_result <= res;
      sig_branch <= br;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven scoreboard bench for alu
module tb_alu;
  logic        clk, rst_n;
  logic [5:0]  opcode, ALU_control;
  logic [31:0] rs_content, rt_content, ALU_result;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic        sig_branch;
  int          n_chk, n_fail;

  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic [31:0] rs, rt;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] res;
    logic        br;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] res;
    logic        br;
  } exp_t;

  vec_t v[$];
  exp_t q[$];

  alu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rs_content(rs_content),
    .rt_content(rt_content), .shamt(shamt), .ALU_control(ALU_control),
    .immediate(immediate), .ALU_result(ALU_result), .sig_branch(sig_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] fn, logic [31:0] rs,
                              logic [31:0] rt, logic [4:0] sh, logic [15:0] imm,
                              logic [31:0] res, logic br);
    vec_t t;
    t.name = n; t.op = op; t.fn = fn; t.rs = rs; t.rt = rt;
    t.sh = sh; t.imm = imm; t.res = res; t.br = br;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(vec_t t);
    exp_t e;
    opcode = t.op; ALU_control = t.fn; rs_content = t.rs; rt_content = t.rt;
    shamt = t.sh; immediate = t.imm;
    e.name = t.name; e.res = t.res; e.br = t.br;
    q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected pending result");
    end else begin
      e = q.pop_front();
      chk({e.name, " result"}, ALU_result, e.res);
      chk({e.name, " branch"}, {31'b0, sig_branch}, {31'b0, e.br});
    end
  endtask

  task automatic apply(vec_t t);
    @(negedge clk);
    drive(t);
    @(posedge clk);
    #1;
    sample();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    v.push_back(mk("srl12", 6'o00, 6'b000010, 0, 12, 1, 0, 6, 0));
    v.push_back(mk("srl22", 6'o00, 6'b000010, 0, 22, 1, 0, 11, 0));
    v.push_back(mk("srl35", 6'o00, 6'b000010, 0, 35, 1, 0, 17, 0));
    v.push_back(mk("add_ovf", 6'o00, 6'b100000, 32'h7FFFFFFF, 1, 0, 0, 32'h80000000, 0));
    v.push_back(mk("addu", 6'o00, 6'b100001, 32'hFFFFFFFF, 2, 0, 0, 1, 0));
    v.push_back(mk("sub", 6'o00, 6'b100010, 5, 7, 0, 0, 32'hFFFFFFFE, 0));
    v.push_back(mk("subu", 6'o00, 6'b100011, 0, 1, 0, 0, 32'hFFFFFFFF, 0));
    v.push_back(mk("slt_neg", 6'o00, 6'b101010, 32'hFFFFFFFF, 1, 0, 0, 1, 0));
    v.push_back(mk("sltu_neg", 6'o00, 6'b101011, 32'hFFFFFFFF, 1, 0, 0, 0, 0));
    v.push_back(mk("sltu_0max", 6'o00, 6'b101011, 0, 32'hFFFFFFFF, 0, 0, 1, 0));
    v.push_back(mk("slt_0max", 6'o00, 6'b101010, 0, 32'hFFFFFFFF, 0, 0, 0, 0));
    v.push_back(mk("sra4", 6'o00, 6'b000011, 0, 32'h80000000, 4, 0, 32'hF8000000, 0));
    v.push_back(mk("sra31", 6'o00, 6'b000011, 0, 32'h80000001, 31, 0, 32'hFFFFFFFF, 0));
    v.push_back(mk("srl31", 6'o00, 6'b000010, 0, 32'h80000001, 31, 0, 1, 0));
    v.push_back(mk("sll0", 6'o00, 6'b000000, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0));
    v.push_back(mk("sll4", 6'o00, 6'b000000, 0, 32'h0000000F, 4, 0, 32'h000000F0, 0));
    v.push_back(mk("sllv", 6'o00, 6'b000100, 33, 1, 7, 0, 2, 0));
    v.push_back(mk("srav", 6'o00, 6'b000111, 4, 32'h80000000, 0, 0, 32'hF8000000, 0));
    v.push_back(mk("srlv", 6'o00, 6'b000110, 36, 32'h80000000, 0, 0, 32'h08000000, 0));
    v.push_back(mk("and", 6'o00, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hF000F000, 0));
    v.push_back(mk("or", 6'o00, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hFFF0FFF0, 0));
    v.push_back(mk("xor", 6'o00, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h0FF00FF0, 0));
    v.push_back(mk("nor", 6'o00, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h000F000F, 0));
    v.push_back(mk("bad_funct", 6'o00, 6'b111111, 32'h12345678, 32'h12345678, 3, 0, 0, 0));
    v.push_back(mk("addi", 6'b001000, 0, 10, 0, 0, 16'hFFFF, 9, 0));
    v.push_back(mk("addiu", 6'b001001, 0, 32'hFFFFFFFF, 0, 0, 16'h0001, 0, 0));
    v.push_back(mk("slti", 6'b001010, 0, 32'hFFFFFFFE, 0, 0, 16'hFFFF, 1, 0));
    v.push_back(mk("slti_ge", 6'b001010, 0, 5, 0, 0, 16'hFFFF, 0, 0));
    v.push_back(mk("sltiu", 6'b001011, 0, 5, 0, 0, 16'hFFFF, 1, 0));
    v.push_back(mk("andi", 6'b001100, 0, 32'hFFFFFFFF, 0, 0, 16'h8001, 32'h00008001, 0));
    v.push_back(mk("ori", 6'b001101, 0, 0, 0, 0, 16'h8001, 32'h00008001, 0));
    v.push_back(mk("xori", 6'b001110, 0, 32'h0000FFFF, 0, 0, 16'h00FF, 32'h0000FF00, 0));
    v.push_back(mk("lui", 6'b001111, 0, 32'hAAAAAAAA, 0, 0, 16'h1234, 32'h12340000, 0));
    v.push_back(mk("lw", 6'b100011, 0, 100, 0, 0, 16'hFFFC, 96, 0));
    v.push_back(mk("sw", 6'b101011, 0, 32'h1000, 0, 0, 16'h0010, 32'h1010, 0));
    v.push_back(mk("beq_eq", 6'b000100, 0, 4, 4, 0, 0, 0, 1));
    v.push_back(mk("bne_eq", 6'b000101, 0, 4, 4, 0, 0, 0, 0));
    v.push_back(mk("beq_ne", 6'b000100, 0, 4, 5, 0, 0, 0, 0));
    v.push_back(mk("bne_ne", 6'b000101, 0, 4, 5, 0, 0, 0, 1));
    v.push_back(mk("bgtz0", 6'b000111, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk("bgtz1", 6'b000111, 0, 1, 0, 0, 0, 0, 1));
    v.push_back(mk("bgtz_neg", 6'b000111, 0, 32'h80000000, 0, 0, 0, 0, 0));
    v.push_back(mk("blez_m1", 6'b000110, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1));
    v.push_back(mk("blez0", 6'b000110, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk("blez1", 6'b000110, 0, 1, 0, 0, 0, 0, 0));
    v.push_back(mk("bad_op", 6'b111111, 6'b100000, 7, 7, 0, 16'hFFFF, 0, 0));
    v.push_back(mk("lui_last", 6'b001111, 0, 0, 0, 0, 16'hBEEF, 32'hBEEF0000, 0));

    opcode = 6'b001111; ALU_control = 0; rs_content = 0; rt_content = 0;
    shamt = 0; immediate = 16'h5555;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset result", ALU_result, 0);
    chk("reset branch", {31'b0, sig_branch}, 0);
    @(posedge clk);
    #1;
    chk("reset held result", ALU_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release no update", ALU_result, 0);

    foreach (v[i]) apply(v[i]);

    @(negedge clk);
    drive(mk("inflight", 6'o00, 6'b100000, 1, 2, 0, 0, 3, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset result", ALU_result, 0);
    chk("async reset branch", {31'b0, sig_branch}, 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("reset discards inflight", ALU_result, 0);
    @(negedge clk);
    drive(mk("post_reset_sub", 6'o00, 6'b100010, 10, 3, 0, 0, 7, 0));
    rst_n = 1'b1;
    #1;
    chk("deassert no glitch", ALU_result, 0);
    @(posedge clk);
    #1;
    sample();
    apply(mk("post_reset_beq", 6'b000100, 0, 9, 9, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Single-cycle-issue, registered 32-bit integer ALU for the MIPS-style datapath in the execute stage. It decodes the instruction `opcode` and, for R-type instructions, the function field on `ALU_control`. It computes the arithmetic, logic, shift or compare result from the register operands, shift amount and immediate, and raises `sig_branch` when a branch condition holds. Both outputs are registered, with one cycle of latency.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `opcode`  input  6  instruction opcode field.
- `rs_content`  input  32  rs register operand.
- `rt_content`  input  32  rt register operand.
- `shamt`  input  5  shift amount field.
- `ALU_control`  input  6  function field; used only when `opcode`=000000.
- `immediate`  input  16  I-type immediate field.
- `ALU_result`  output  32  registered result.
- `sig_branch`  output  1  registered branch-taken flag.

## Operation
Extension rules for `immediate`:
- SE = sign-extended.
- ZE = zero-extended.

All arithmetic is modulo 2^32; overflow never traps or flags.

R-type (`opcode`=000000), selected by `ALU_control`:
- 000000 SLL: rt << shamt.
- 000010 SRL: rt >> shamt, logical.
- 000011 SRA: rt >>> shamt, arithmetic.
- 000100 SLLV, 000110 SRLV, 000111 SRAV: as SLL/SRL/SRA, with the shift amount taken from rs[4:0].
- 100000 ADD, 100001 ADDU: rs + rt.
- 100010 SUB, 100011 SUBU: rs − rt.
- 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise on rs, rt.
- 101010 SLT: result is 1 if rs < rt signed, else 0.
- 101011 SLTU: result is 1 if rs < rt unsigned, else 0.
- Any other funct: result 0.

I-type, selected by `opcode`:
- 001000 ADDI, 001001 ADDIU: rs + SE.
- 001010 SLTI: signed rs < SE.
- 001011 SLTIU: unsigned rs < SE.
- 001100 ANDI, 001101 ORI, 001110 XORI: rs op ZE.
- 001111 LUI: {immediate, 16'h0000}.
- 100011 LW, 101011 SW: rs + SE (effective address).

Branches (result 0, `sig_branch` set when the condition is true):
- 000100 BEQ: rs == rt.
- 000101 BNE: rs != rt.
- 000110 BLEZ: rs ≤ 0, signed.
- 000111 BGTZ: rs > 0, signed.

Other rules:
- `sig_branch` is 0 for every non-branch opcode.
- Unlisted opcode: result 0, `sig_branch` 0.
- Next-state logic is purely combinational from the current inputs. No internal state exists beyond the two output registers.

## Timing
- Reset: while `rst_n`=0, `ALU_result`=0 and `sig_branch`=0, immediately and independent of `clk`.
- Latency: inputs sampled at rising edge N produce outputs valid after edge N and held until edge N+1.
- No handshake; a new operation may be presented every cycle, giving throughput of 1 per clock.
- When `rst_n` deasserts, the first update occurs at the next rising edge.
- Reset asserted mid-stream discards the in-flight result; no output glitches on the deasserting edge.
- Boundaries:
  - shamt=0 passes rt unchanged.
  - shamt=31 on SRA of a negative rt gives 32'hFFFFFFFF.
  - ADD 32'h7FFFFFFF + 1 gives 32'h80000000 with no flag.
  - SLTU of 0 < 32'hFFFFFFFF gives 1; SLT of the same operands gives 0.

## Test plan
- SRL: opcode=0, ALU_control=000010, shamt=1, rt=12, 22, 35 on successive cycles -> ALU_result=6, 11, 17 one cycle after each; sig_branch=0.
- Reset: drive rst_n=0 mid-operation with any inputs -> outputs 0 at once; after release, next edge loads the new result.
- Arithmetic/compare:
  - ADD 32'h7FFFFFFF+1 -> 32'h80000000.
  - SUB 5−7 -> 32'hFFFFFFFE.
  - SLT rs=−1, rt=1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts: SRA rt=32'h80000000, shamt=4 -> 32'hF8000000; SLLV rs=33, rt=1 -> 2 (uses rs[4:0]=1).
- Immediates:
  - ADDI rs=10, imm=16'hFFFF -> 9.
  - ORI rs=0, imm=16'h8001 -> 32'h00008001.
  - LUI imm=16'h1234 -> 32'h12340000.
- Branches:
  - BEQ rs=rt=4 -> sig_branch=1, result 0.
  - BNE with the same operands -> 0.
  - BGTZ rs=0 -> 0.
  - BLEZ rs=32'hFFFFFFFF -> 1.
